// File: rtl/vrc7_audio_post.sv
// rtl/vrc7_audio_post.sv - VRC7 expansion audio post-processing: DC block, optional LPF, gain ramp, saturation
// Optional stage-3 low-pass is compiled in when VRC7_AUD_LPF_EN is defined.
module vrc7_audio_post #(
    parameter int DCB_SHIFT = 8,
    parameter int LPF_SHIFT = 2,
    parameter int RAMP_STEP = 1
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic        [10:0] smp_in,
    input  logic               smp_stb,
    input  logic               mute,
    output logic signed [15:0] snd,
    output logic               snd_stb,
    output logic        [8:0]  gain_mon
);
    localparam logic [9:0] GAIN_MAX = 10'd256;
    localparam logic [9:0] STEP     = 10'(RAMP_STEP);

    function automatic logic signed [15:0] sat16(input logic signed [25:0] v);
        if (v > 26'sd32767)
            return 16'sh7fff;
        else if (v < -26'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    logic signed [16:0] x_prev_q;
    logic signed [17:0] d1_q;
    logic               v1_q, mute1_q;
    logic signed [19:0] y_q;
    logic               v2_q, mute2_q;
    logic signed [15:0] snd_q;
    logic               snd_stb_q;
    logic        [8:0]  gain_q, gain_d;

    logic signed [16:0] x_d;
    logic signed [17:0] d_d;
    logic signed [19:0] d_ext, y_leak, y_d;
    logic signed [25:0] y_ext, val_ext, gain_ext, p, p_sh;
    logic signed [15:0] y_sat, stage_val;

    // Recentring the unsigned sample around 1024 is just an MSB flip.
    assign x_d = {~smp_in[10], ~smp_in[10], smp_in[9:0], 5'b0};
    assign d_d = {x_d[16], x_d} - {x_prev_q[16], x_prev_q};

    assign d_ext  = {{2{d1_q[17]}}, d1_q};
    assign y_leak = y_q >>> DCB_SHIFT;
    assign y_d    = y_q + d_ext - y_leak;

    assign y_ext = {{6{y_q[19]}}, y_q};
    assign y_sat = sat16(y_ext);

`ifdef VRC7_AUD_LPF_EN
    logic signed [15:0] z_q, z_d;
    logic signed [16:0] lpf_diff, lpf_step;

    always_comb begin
        lpf_diff = {y_sat[15], y_sat} - {z_q[15], z_q};
        lpf_step = lpf_diff >>> LPF_SHIFT;
        z_d      = 16'({z_q[15], z_q} + lpf_step);
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n)
            z_q <= '0;
        else if (v2_q)
            z_q <= z_d;
    end

    assign stage_val = z_d;
`else
    assign stage_val = y_sat;
`endif

    // The product uses the gain held before this sample's ramp step.
    assign val_ext  = {{10{stage_val[15]}}, stage_val};
    assign gain_ext = {17'b0, gain_q};
    assign p        = val_ext * gain_ext;
    assign p_sh     = p >>> 8;

    always_comb begin
        gain_d = gain_q;
        if (mute2_q)
            gain_d = ({1'b0, gain_q} > STEP) ? 9'({1'b0, gain_q} - STEP) : 9'd0;
        else
            gain_d = (({1'b0, gain_q} + STEP) >= GAIN_MAX) ? 9'd256 : 9'({1'b0, gain_q} + STEP);
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            x_prev_q  <= '0;
            d1_q      <= '0;
            v1_q      <= 1'b0;
            mute1_q   <= 1'b0;
            y_q       <= '0;
            v2_q      <= 1'b0;
            mute2_q   <= 1'b0;
            snd_q     <= '0;
            snd_stb_q <= 1'b0;
            gain_q    <= '0;
        end else begin
            v1_q      <= smp_stb;
            v2_q      <= v1_q;
            snd_stb_q <= v2_q;
            if (smp_stb) begin
                x_prev_q <= x_d;
                d1_q     <= d_d;
                mute1_q  <= mute;
            end
            if (v1_q) begin
                y_q     <= y_d;
                mute2_q <= mute1_q;
            end
            if (v2_q) begin
                snd_q  <= sat16(p_sh);
                gain_q <= gain_d;
            end
        end
    end

    assign snd      = snd_q;
    assign snd_stb  = snd_stb_q;
    assign gain_mon = gain_q;
endmodule

// File: tb/tb_vrc7_audio_post.sv
// tb/tb_vrc7_audio_post.sv - directed self-checking bench for vrc7_audio_post
module tb_vrc7_audio_post;
    logic               clk = 1'b0;
    logic               res_n = 1'b0;
    logic        [10:0] smp_in = 11'd1024;
    logic               smp_stb = 1'b0;
    logic               mute = 1'b0;
    logic signed [15:0] snd;
    logic               snd_stb;
    logic        [8:0]  gain_mon;

    int n_cmp = 0;
    int n_err = 0;

    vrc7_audio_post dut (
        .clk(clk), .res_n(res_n), .smp_in(smp_in), .smp_stb(smp_stb),
        .mute(mute), .snd(snd), .snd_stb(snd_stb), .gain_mon(gain_mon)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [10:0] s, input logic m, output int lat,
                          output logic signed [15:0] o);
        smp_in  = s;
        mute    = m;
        smp_stb = 1'b1;
        tick();
        smp_stb = 1'b0;
        lat = -1;
        o   = '0;
        for (int i = 1; i <= 6; i++) begin
            if (snd_stb === 1'b1) begin
                lat = i;
                o   = snd;
                break;
            end
            tick();
        end
    endtask

    task automatic do_reset();
        res_n   = 1'b0;
        smp_stb = 1'b0;
        mute    = 1'b0;
        tick();
        tick();
        res_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        res_n   = 1'b0;
        smp_stb = 1'b0;
        tick();
        tick();
        n_cmp++; if (snd !== 16'sd0) begin n_err++; $display("FAIL reset_snd: got %0d want 0", snd); end
        n_cmp++; if (snd_stb !== 1'b0) begin n_err++; $display("FAIL reset_stb: got %b want 0", snd_stb); end
        n_cmp++; if (gain_mon !== 9'd0) begin n_err++; $display("FAIL reset_gain: got %0d want 0", gain_mon); end
        res_n = 1'b1;
        tick();
    endtask

    task automatic test_ramp_silence();
        int lat;
        logic signed [15:0] o;
        for (int i = 1; i <= 256; i++) begin
            strobe(11'd1024, 1'b0, lat, o);
            n_cmp++; if (lat != 3) begin n_err++; $display("FAIL ramp_latency[%0d]: got %0d want 3", i, lat); end
            n_cmp++; if (o !== 16'sd0) begin n_err++; $display("FAIL ramp_snd[%0d]: got %0d want 0", i, o); end
            n_cmp++; if (gain_mon !== 9'(i)) begin n_err++; $display("FAIL ramp_gain[%0d]: got %0d want %0d", i, gain_mon, i); end
        end
    endtask

    task automatic test_step();
        int lat;
        logic signed [15:0] o;
        logic signed [15:0] want;
`ifdef VRC7_AUD_LPF_EN
        want = 16'sd512;
`else
        want = 16'sd2048;
`endif
        strobe(11'd1088, 1'b0, lat, o);
        n_cmp++; if (lat != 3) begin n_err++; $display("FAIL step_latency: got %0d want 3", lat); end
        n_cmp++; if (o !== want) begin n_err++; $display("FAIL step_snd: got %0d want %0d", o, want); end
    endtask

    task automatic test_saturation();
        int lat;
        logic signed [15:0] o;
        logic signed [15:0] want_lo, want_hi;
`ifdef VRC7_AUD_LPF_EN
        want_lo = -16'sd8192;
        want_hi = 16'sd2047;
`else
        want_lo = -16'sd32768;
        want_hi = 16'sd32767;
`endif
        strobe(11'd0, 1'b0, lat, o);
        n_cmp++; if (o !== want_lo) begin n_err++; $display("FAIL sat_low: got %0d want %0d", o, want_lo); end
        strobe(11'd2047, 1'b0, lat, o);
        n_cmp++; if (o !== want_hi) begin n_err++; $display("FAIL sat_high: got %0d want %0d", o, want_hi); end
    endtask

    task automatic test_decay();
        int lat, a, prev_a;
        logic signed [15:0] o;
        for (int i = 0; i < 4096; i++) begin
            strobe(11'd2047, 1'b0, lat, o);
            n_cmp++; if (lat != 3) begin n_err++; $display("FAIL hold_latency[%0d]: got %0d want 3", i, lat); end
        end
        prev_a = 32768;
        for (int i = 0; i < 4096; i++) begin
            strobe(11'd1600, 1'b0, lat, o);
            a = (o < 0) ? -int'(o) : int'(o);
            if (i == 0) begin
                n_cmp++; if (!(o < 0)) begin n_err++; $display("FAIL decay_first_sign: got %0d want negative", o); end
            end
            if (i >= 32) begin
                n_cmp++; if (a > prev_a) begin n_err++; $display("FAIL decay_monotonic[%0d]: got |%0d| want <= %0d", i, o, prev_a); end
            end
            prev_a = a;
        end
        n_cmp++; if (prev_a >= 16) begin n_err++; $display("FAIL decay_final: got |snd|=%0d want < 16", prev_a); end
    endtask

    task automatic test_mute_ramp();
        int lat, g;
        logic signed [15:0] o;
        g = 256;
        for (int i = 0; i < 630; i++) begin
            logic m;
            m = (i < 100) || (i >= 150 && i < 370);
            strobe(11'd1600, m, lat, o);
            g = m ? ((g > 0) ? g - 1 : 0) : ((g < 256) ? g + 1 : 256);
            n_cmp++; if (gain_mon !== 9'(g)) begin n_err++; $display("FAIL mute_gain[%0d]: got %0d want %0d", i, gain_mon, g); end
            if (i == 99) begin
                n_cmp++; if (gain_mon !== 9'd156) begin n_err++; $display("FAIL mute_gain_156: got %0d want 156", gain_mon); end
            end
            if (i == 149) begin
                n_cmp++; if (gain_mon !== 9'd206) begin n_err++; $display("FAIL mute_gain_206: got %0d want 206", gain_mon); end
            end
        end
        n_cmp++; if (gain_mon !== 9'd256) begin n_err++; $display("FAIL mute_gain_hold_max: got %0d want 256", gain_mon); end
    endtask

    task automatic test_reset_midstream();
        int lat;
        logic signed [15:0] o;
        for (int c = 0; c < 6; c++) begin
            smp_in  = c[0] ? 11'd2047 : 11'd0;
            mute    = 1'b0;
            smp_stb = 1'b1;
            tick();
        end
        smp_stb = 1'b0;
        res_n   = 1'b0;
        #1;
        n_cmp++; if (snd !== 16'sd0) begin n_err++; $display("FAIL midrst_snd: got %0d want 0", snd); end
        n_cmp++; if (gain_mon !== 9'd0) begin n_err++; $display("FAIL midrst_gain: got %0d want 0", gain_mon); end
        n_cmp++; if (snd_stb !== 1'b0) begin n_err++; $display("FAIL midrst_stb: got %b want 0", snd_stb); end
        tick();
        res_n = 1'b1;
        strobe(11'd1600, 1'b0, lat, o);
        n_cmp++; if (lat != 3) begin n_err++; $display("FAIL midrst_latency: got %0d want 3", lat); end
        n_cmp++; if (o !== 16'sd0) begin n_err++; $display("FAIL midrst_first_snd: got %0d want 0", o); end
        n_cmp++; if (gain_mon !== 9'd1) begin n_err++; $display("FAIL midrst_gain_after: got %0d want 1", gain_mon); end
    endtask

    task automatic test_pre_gain();
        int lat;
        logic signed [15:0] o;
        logic signed [15:0] want;
`ifdef VRC7_AUD_LPF_EN
        want = 16'sd3;
`else
        want = 16'sd7;
`endif
        strobe(11'd1088, 1'b0, lat, o);
        n_cmp++; if (o !== 16'sd0) begin n_err++; $display("FAIL pregain_first: got %0d want 0", o); end
        strobe(11'd1088, 1'b0, lat, o);
        n_cmp++; if (o !== want) begin n_err++; $display("FAIL pregain_second: got %0d want %0d", o, want); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat;
        logic       exp_stb;
        pat = 8'b1011_1011;
        for (int c = 0; c < 12; c++) begin
            smp_in  = 11'd1024;
            mute    = 1'b0;
            smp_stb = (c < 8) ? pat[c] : 1'b0;
            tick();
            exp_stb = (c >= 2 && c < 10) ? pat[c - 2] : 1'b0;
            n_cmp++; if (snd_stb !== exp_stb) begin n_err++; $display("FAIL b2b_stb[%0d]: got %b want %b", c, snd_stb, exp_stb); end
        end
        smp_stb = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp_silence();
        test_step();
        do_reset();
        test_ramp_silence();
        test_saturation();
        test_decay();
        test_mute_ramp();
        test_reset_midstream();
        do_reset();
        test_pre_gain();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vrc7_audio_post.md
Name: vrc7_audio_post

Overview:
- Audio post-processing stage directly downstream of the expansion-sound generator in the VRC7 mapper.
- Consumes the generator's 11-bit unsigned mix sample and produces the signed 16-bit mapper sound output.
- Processing order: DC-blocking high-pass, then optional one-pole low-pass, then a click-free mute/unmute gain ramp, then saturation.
- Runs on the CPU M2 clock.

Parameters:
- DCB_SHIFT, 8, DC-blocker leak shift; pole = 1 - 2^-DCB_SHIFT.
- LPF_SHIFT, 2, low-pass smoothing shift; used only when the optional feature is compiled in.
- RAMP_STEP, 1, gain change per accepted sample, in 1/256 units.

Ports:
- clk  in  1  CPU M2 clock; all state changes on its rising edge.
- res_n  in  1  asynchronous active-low reset.
- smp_in  in  11  unsigned generator sample; midpoint is 1024.
- smp_stb  in  1  one-clk pulse: smp_in is valid; may assert every clk.
- mute  in  1  1 = ramp gain toward 0; 0 = ramp gain toward 256.
- snd  out  16  signed processed sample.
- snd_stb  out  1  one-clk pulse: snd has just updated.
- gain_mon  out  9  current gain, 0..256, for the save-state and debug readout.

Behaviour:
- Reset (res_n low, asynchronous):
  - All internal state cleared, including x_prev, y, z, pipeline data and valid bits.
  - gain = 0 (power-up is silent, then fades in).
  - snd = 0, snd_stb = 0.
- Reset asserted mid-pipeline discards in-flight samples; no snd_stb is produced for them.
- Pipeline structure:
  - Three stages, each advancing only when its valid bit is set.
  - Fully pipelined: no backpressure and no busy state.
  - snd_stb asserts exactly 3 clks after the smp_stb that produced it.
  - Back-to-back strobes give back-to-back outputs.
- Stage 1 (capture):
  - x = ({smp_in} - 1024) << 5, computed as a 17-bit signed value in the range -32768..+32736.
  - d = x - x_prev, 18-bit signed.
  - x_prev <= x.
- Stage 2 (DC blocker):
  - y <= y + d - (y >>> DCB_SHIFT).
  - y is a 20-bit signed accumulator; the shift is arithmetic.
  - y is never saturated internally; 20 bits bound it.
- Stage 3 (low-pass, gain, saturation):
  - Low-pass (feature on): z <= z + ((sat16(y) - z) >>> LPF_SHIFT), 16-bit signed. The value passed on is z.
  - Low-pass (feature off): sat16(y) is passed on directly.
  - Gain: p = value * gain, 25-bit signed; snd <= sat16(p >>> 8).
  - sat16 clamps to the range +32767 / -32768.
- Gain ramp:
  - Evaluated once per accepted sample, in the same clk as stage 3, using that sample's mute value captured at stage 1.
  - The multiply uses the pre-update gain.
  - mute=0: gain <= min(gain + RAMP_STEP, 256).
  - mute=1: gain <= max(gain - RAMP_STEP, 0).
  - At 0 or 256 the gain holds, with no wrap in either direction.
- A mute toggle mid-ramp reverses direction from the current value; the gain never jumps.
- gain_mon reflects the gain register directly.
- Between strobes, snd holds its last value.

Optional Feature:
- Macro: VRC7_AUD_LPF_EN.
- Defined: stage-3 low-pass is present as described above.
- Undefined:
  - The z register and LPF_SHIFT logic are removed; stage 3 uses sat16(y).
  - Latency stays 3 clks; all other behaviour is identical.

Test Plan:
- Reset, then mute=0 and 256 strobes of smp_in=1024: snd stays 0 on every snd_stb, gain_mon reaches 256 after strobe 256, 256 snd_stb pulses each 3 clks after its strobe.
- After the previous test, one strobe of smp_in=1088 (x=+2048): feature off gives snd=2048; feature on gives snd=512.
- After the first test (feature off), strobe smp_in=0 then smp_in=2047: first snd=-32768; second has y=32864 and is required to saturate to snd=32767.
- Constant smp_in=1600 held for 4096 strobes at gain 256: snd magnitude decays monotonically toward 0 and ends with |snd| < 16.
- At gain 256, set mute=1 for 100 strobes then mute=0 for 50: gain_mon goes 256 -> 156 -> 206, stepping by 1 per strobe; it holds at 0 and 256 when the bench drives past either limit.
- Assert res_n=0 for 1 clk between two strobes of a continuous 1-clk strobe stream: no snd_stb for in-flight samples, snd=0 and gain_mon=0 immediately, and the next strobe yields a snd_stb 3 clks later.
